red_led_driver: RTL and testbench

Output conditioning stage between the red-LED PIO register and the board LEDR pins. It takes the 16-bit LED pattern word, a per-LED blink mask and a 4-bit global brightness code. It produces registered, PWM-dimmed, optionally blinking pin drive. Brightness changes are glitch-free: the block latches a new duty only at a PWM period boundary.

---
 rtl/led_drv_pkg.sv | 10 +
 rtl/red_led_driver_tick_divider.sv | 16 +
 rtl/red_led_driver.sv | 50 +++++
 tb/tb_red_led_driver.sv | 126 ++++++++++++
 4 files changed

// File: rtl/led_drv_pkg.sv
// led_drv_pkg: shared defaults and helpers for the red LED output driver.
package led_drv_pkg;
    localparam int LED_WIDTH = 16;
    localparam int LED_PWM_BITS = 4;
    localparam int LED_BLINK_DIV_50MHZ = 25_000_000;

    function automatic logic duty_full(input logic [31:0] d, input int bits);
        return d == (32'd1 << bits) - 32'd1;
    endfunction
endpackage

// File: rtl/red_led_driver_tick_divider.sv
// tick_divider: one-cycle tick every DIV clocks, counting 0..DIV-1.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    logic [CW-1:0] r_cnt;
    assign o_tick = r_cnt == CW'(DIV - 1);
    always_ff @(posedge i_clk) begin
        if (i_reset || o_tick) r_cnt <= '0;
        else r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/red_led_driver.sv
// red_led_driver: registered, PWM-dimmed, optionally blinking LEDR drive.
// Duty is only latched at the PWM wrap so a running pulse is never cut short.
module red_led_driver
    import led_drv_pkg::*;
#(
    parameter int WIDTH     = LED_WIDTH,
    parameter int PWM_BITS  = LED_PWM_BITS,
    parameter int BLINK_DIV = LED_BLINK_DIV_50MHZ
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [WIDTH-1:0]    i_pattern,
    input  logic [WIDTH-1:0]    i_blink_mask,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic [WIDTH-1:0]    o_ledr,
    output logic                o_blink_phase
);
    logic [WIDTH-1:0]    r_pattern, r_mask, r_ledr;
    logic [PWM_BITS-1:0] r_duty, r_pwm_cnt;
    logic                r_phase, w_tick, w_pwm_on;

    tick_divider #(.DIV(BLINK_DIV)) u_blink (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    assign w_pwm_on = duty_full(32'(r_duty), PWM_BITS) || (r_pwm_cnt < r_duty);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pattern <= '0;
            r_mask    <= '0;
            r_duty    <= '0;
            r_pwm_cnt <= '0;
            r_phase   <= 1'b1;
            r_ledr    <= '0;
        end else begin
            r_pattern <= i_pattern;
            r_mask    <= i_blink_mask;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (&r_pwm_cnt) r_duty <= i_duty;
            if (w_tick) r_phase <= ~r_phase;
            r_ledr    <= r_pattern & {WIDTH{w_pwm_on}} & (~r_mask | {WIDTH{r_phase}});
        end
    end

    assign o_ledr        = r_ledr;
    assign o_blink_phase = r_phase;
endmodule

// File: tb/tb_red_led_driver.sv
// tb_red_led_driver: directed stimulus with a cycle-indexed scoreboard of expected pin states.
module tb_red_led_driver;
    typedef struct {
        int          cyc;
        bit          cl;
        logic [15:0] l;
        bit          cp;
        logic        p;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pattern, mask;
    logic [3:0]  duty;
    logic [15:0] ledr;
    logic        phase;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    red_led_driver #(.WIDTH(16), .PWM_BITS(4), .BLINK_DIV(4)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_pattern     (pattern),
        .i_blink_mask  (mask),
        .i_duty        (duty),
        .o_ledr        (ledr),
        .o_blink_phase (phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input bit cl, input logic [15:0] l,
                        input bit cp, input logic p, input string tag);
        exp_t e;
        e.cyc = c; e.cl = cl; e.l = l; e.cp = cp; e.p = p; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // blink phase after posedge c, counting from the reset release at edge r
    function automatic logic bphase(input int c, input int r);
        return 1'b1 ^ 1'(((c - r) / 4) & 1);
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $error("FAIL %s missed cyc=%0d now=%0d", e.tag, e.cyc, cyc);
            end else begin
                if (e.cl) begin
                    checks++;
                    assert (ledr === e.l) else begin
                        errors++;
                        $error("FAIL %s ledr cyc=%0d got=%h exp=%h", e.tag, cyc, ledr, e.l);
                    end
                end
                if (e.cp) begin
                    checks++;
                    assert (phase === e.p) else begin
                        errors++;
                        $error("FAIL %s phase cyc=%0d got=%b exp=%b", e.tag, cyc, phase, e.p);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; pattern = 16'hFFFF; mask = 16'h0; duty = 4'hF;
        // reset held for edges 1..3, released from edge 4; duty_q loads at edge 19
        for (int c = 1; c <= 19; c++) push(c, 1, 16'h0, c <= 7, c <= 6, "reset");
        push(20, 1, 16'hFFFF, 0, 1'b0, "first_on");
        tick_to(3);
        reset = 1'b0;
        tick_to(20);
        pattern = 16'hA5A5;
        push(21, 1, 16'hFFFF, 0, 1'b0, "full_lat");
        for (int c = 22; c <= 85; c++) push(c, 1, 16'hA5A5, 0, 1'b0, "full");
        tick_to(85);
        pattern = 16'h0001; duty = 4'h4;
        push(86, 1, 16'hA5A5, 0, 1'b0, "pwm_lat");
        for (int c = 87; c <= 99; c++) push(c, 1, 16'h0001, 0, 1'b0, "pwm_old");
        for (int c = 100; c <= 131; c++)
            push(c, 1, ((c - 100) % 16 < 4) ? 16'h0001 : 16'h0, 0, 1'b0, "pwm4");
        tick_to(120);
        duty = 4'h0;
        for (int c = 132; c <= 147; c++) push(c, 1, 16'h0, 0, 1'b0, "pwm0");
        tick_to(140);
        duty = 4'h4;
        for (int c = 148; c <= 163; c++)
            push(c, 1, (c - 148 < 4) ? 16'h0001 : 16'h0, 0, 1'b0, "glitch_cur");
        tick_to(149);
        duty = 4'hC;
        for (int c = 164; c <= 179; c++)
            push(c, 1, (c - 164 < 12) ? 16'h0001 : 16'h0, 0, 1'b0, "glitch_next");
        tick_to(180);
        duty = 4'hF; pattern = 16'h00FF; mask = 16'h000F;
        for (int c = 196; c <= 233; c++)
            push(c, 1, bphase(c - 1, 3) ? 16'h00FF : 16'h00F0, 1, bphase(c, 3), "blink");
        tick_to(233);
        reset = 1'b1;
        for (int c = 234; c <= 238; c++) push(c, c <= 236, 16'h0, 1, c < 238, "rst_mid");
        tick_to(234);
        reset = 1'b0;
        tick_to(240);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $error("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
